// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control types and constants
// Contents:
//   state_t            : hazard controller FSM states (RUN, LU_STALL, MC_WAIT)
//   REG_ZERO           : architectural zero register, never a hazard source
//   *_DEF localparams  : default values for the controller parameters
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MC_WAIT  = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int LOAD_STALL_CYC_DEF = 1;
  localparam int MC_TIMEOUT_DEF     = 64;
  localparam int CNT_W_DEF          = 8;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
// Ports:
//   rs_IF_ID, rt_IF_ID : source registers of the instruction in ID
//   rt_ID_EX           : destination register of the instruction in EX
//   MemRead_ID_EX      : instruction in EX is a load
//   load_use           : ID needs a value the load in EX has not produced yet
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs_IF_ID,
  input  logic [4:0] rt_IF_ID,
  input  logic [4:0] rt_ID_EX,
  input  logic       MemRead_ID_EX,
  output logic       load_use
);

  // r0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign load_use = MemRead_ID_EX && (rt_ID_EX != REG_ZERO) &&
                    ((rt_ID_EX == rs_IF_ID) || (rt_ID_EX == rt_IF_ID));

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - stall/bubble/flush sequencer for a 5-stage pipeline
// Optional feature macro: HAZARD_STALL_STATS_EN (adds stats_clr / stall_cycles)
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   rs_IF_ID, rt_IF_ID          : source registers of the instruction in ID
//   rt_ID_EX, MemRead_ID_EX     : destination / load flag of the instruction in EX
//   branch_taken_EX             : branch resolved taken in EX this cycle
//   mc_start_ID, mc_done        : multi-cycle op in ID / multi-cycle result valid
//   PC_Write, IF_ID_Write,
//   ID_EX_Write                 : pipeline register write enables
//   ID_EX_Bubble, EX_MEM_Bubble : zero control fields (insert NOP)
//   IF_ID_Flush, ID_EX_Flush    : clear pipeline registers
//   mc_timeout                  : one-cycle pulse on forced MC_WAIT exit
//   stats_clr, stall_cycles     : (stats build only) clear / count of PC stall cycles
module hazard_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYC = LOAD_STALL_CYC_DEF,
  parameter int MC_TIMEOUT     = MC_TIMEOUT_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_IF_ID,
  input  logic [4:0]       rt_IF_ID,
  input  logic [4:0]       rt_ID_EX,
  input  logic             MemRead_ID_EX,
  input  logic             branch_taken_EX,
  input  logic             mc_start_ID,
  input  logic             mc_done,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Bubble,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             mc_timeout
`ifdef HAZARD_STALL_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  localparam logic [CNT_W-1:0] LU_RELOAD = CNT_W'(LOAD_STALL_CYC - 1);
  localparam logic [CNT_W-1:0] MC_LAST   = CNT_W'(MC_TIMEOUT - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             load_use;

  hazard_detect u_hazard_detect (
    .rs_IF_ID      (rs_IF_ID),
    .rt_IF_ID      (rt_IF_ID),
    .rt_ID_EX      (rt_ID_EX),
    .MemRead_ID_EX (MemRead_ID_EX),
    .load_use      (load_use)
  );

  // Next-state and Mealy output decode. Outputs react to the inputs in the
  // same cycle so a hazard is held off before it reaches the next register.
  always_comb begin
    nxt_state     = state;
    nxt_cnt       = cnt;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    mc_timeout    = 1'b0;

    case (state)
      RUN: begin
        if (branch_taken_EX) begin
          // The instructions in IF and ID are on the wrong path, so any
          // hazard they raise is moot.
          IF_ID_Flush = 1'b1;
          ID_EX_Flush = 1'b1;
        end else if (load_use) begin
          PC_Write     = 1'b0;
          IF_ID_Write  = 1'b0;
          ID_EX_Bubble = 1'b1;
          if (LOAD_STALL_CYC > 1) begin
            nxt_state = LU_STALL;
            nxt_cnt   = LU_RELOAD;
          end
        end else if (mc_start_ID) begin
          nxt_state = MC_WAIT;
          nxt_cnt   = '0;
        end
      end

      LU_STALL: begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        nxt_cnt      = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          nxt_state = RUN;
        end
      end

      MC_WAIT: begin
        if (mc_done) begin
          nxt_state = RUN;
          nxt_cnt   = '0;
        end else if (cnt >= MC_LAST) begin
          mc_timeout = 1'b1;
          nxt_state  = RUN;
          nxt_cnt    = '0;
        end else begin
          // ID is frozen here, so hazards in ID wait until we are back in RUN.
          PC_Write      = 1'b0;
          IF_ID_Write   = 1'b0;
          ID_EX_Write   = 1'b0;
          EX_MEM_Bubble = 1'b1;
          nxt_cnt       = (&cnt) ? cnt : cnt + CNT_W'(1);
        end
      end

      default: begin
        nxt_state = RUN;
        nxt_cnt   = '0;
      end
    endcase

    // Reset overrides everything combinationally, without waiting for a clock.
    if (!rst_n) begin
      PC_Write      = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      ID_EX_Bubble  = 1'b1;
      EX_MEM_Bubble = 1'b1;
      IF_ID_Flush   = 1'b1;
      ID_EX_Flush   = 1'b1;
      mc_timeout    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stats_clr) begin
      stall_cycles <= '0;
    end else if (!PC_Write && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller
module tb_hazard_stall_controller;

  // {PC_Write, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble,
  //  IF_ID_Flush, ID_EX_Flush, mc_timeout}
  localparam logic [7:0] DEF = 8'b1110_0000;
  localparam logic [7:0] RST = 8'b0001_1110;
  localparam logic [7:0] LU  = 8'b0011_0000;
  localparam logic [7:0] BR  = 8'b1110_0110;
  localparam logic [7:0] MCW = 8'b0000_1000;
  localparam logic [7:0] TO  = 8'b1110_0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] rs_IF_ID = '0, rt_IF_ID = '0, rt_ID_EX = '0;
  logic       MemRead_ID_EX = 1'b0, branch_taken_EX = 1'b0;
  logic       mc_start_ID = 1'b0, mc_done = 1'b0;
  logic       stats_clr = 1'b0;

  logic pcw_a, ifw_a, idw_a, idb_a, exb_a, iff_a, idf_a, to_a;
  logic pcw_b, ifw_b, idw_b, idb_b, exb_b, iff_b, idf_b, to_b;
  logic [7:0] stall_a, stall_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];
  string      qn[$];

  always #5 clk = ~clk;

  hazard_stall_controller #(.LOAD_STALL_CYC(1), .MC_TIMEOUT(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID), .rt_ID_EX(rt_ID_EX),
    .MemRead_ID_EX(MemRead_ID_EX), .branch_taken_EX(branch_taken_EX),
    .mc_start_ID(mc_start_ID), .mc_done(mc_done),
    .PC_Write(pcw_a), .IF_ID_Write(ifw_a), .ID_EX_Write(idw_a),
    .ID_EX_Bubble(idb_a), .EX_MEM_Bubble(exb_a),
    .IF_ID_Flush(iff_a), .ID_EX_Flush(idf_a), .mc_timeout(to_a)
`ifdef HAZARD_STALL_STATS_EN
    , .stats_clr(stats_clr), .stall_cycles(stall_a)
`endif
  );

  hazard_stall_controller #(.LOAD_STALL_CYC(3), .MC_TIMEOUT(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID), .rt_ID_EX(rt_ID_EX),
    .MemRead_ID_EX(MemRead_ID_EX), .branch_taken_EX(branch_taken_EX),
    .mc_start_ID(mc_start_ID), .mc_done(mc_done),
    .PC_Write(pcw_b), .IF_ID_Write(ifw_b), .ID_EX_Write(idw_b),
    .ID_EX_Bubble(idb_b), .EX_MEM_Bubble(exb_b),
    .IF_ID_Flush(iff_b), .ID_EX_Flush(idf_b), .mc_timeout(to_b)
`ifdef HAZARD_STALL_STATS_EN
    , .stats_clr(stats_clr), .stall_cycles(stall_b)
`endif
  );

`ifndef HAZARD_STALL_STATS_EN
  assign stall_a = '0;
  assign stall_b = '0;
`endif

  // Monitor: every cycle carries an output vector; compare mid-cycle.
  initial begin
    logic [7:0] ea, eb, ga, gb;
    string nm;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        eb = qb.pop_front();
        nm = qn.pop_front();
        ga = {pcw_a, ifw_a, idw_a, idb_a, exb_a, iff_a, idf_a, to_a};
        gb = {pcw_b, ifw_b, idw_b, idb_b, exb_b, iff_b, idf_b, to_b};
        checks++;
        if (ga !== ea) begin
          errors++;
          $display("FAIL %s lsc1 got %b exp %b", nm, ga, ea);
        end
        checks++;
        if (gb !== eb) begin
          errors++;
          $display("FAIL %s lsc3 got %b exp %b", nm, gb, eb);
        end
      end
    end
  end

  task automatic step(input logic rn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rtex, input logic mr, input logic br,
                      input logic ms, input logic md,
                      input logic [7:0] ea, input logic [7:0] eb, input string nm);
    @(posedge clk);
    #1;
    rst_n           = rn;
    rs_IF_ID        = rs;
    rt_IF_ID        = rt;
    rt_ID_EX        = rtex;
    MemRead_ID_EX   = mr;
    branch_taken_EX = br;
    mc_start_ID     = ms;
    mc_done         = md;
    qa.push_back(ea);
    qb.push_back(eb);
    qn.push_back(nm);
  endtask

  task automatic idle(input logic [7:0] ea, input logic [7:0] eb, input string nm);
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && qa.size() > 0; i++) @(posedge clk);
    checks++;
    if (qa.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d exp 0", qa.size());
    end
  endtask

  task automatic check_stats(input logic [7:0] ea, input logic [7:0] eb, input string nm);
    @(negedge clk);
    checks++;
    if (stall_a !== ea) begin
      errors++;
      $display("FAIL %s stall_cycles lsc1 got %0d exp %0d", nm, stall_a, ea);
    end
    checks++;
    if (stall_b !== eb) begin
      errors++;
      $display("FAIL %s stall_cycles lsc3 got %0d exp %0d", nm, stall_b, eb);
    end
  endtask

  initial begin
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RST, RST, "reset");
    idle(DEF, DEF, "post_reset");

    // load-use on rs
    step(1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU, "lu_rs");
    idle(DEF, LU, "lu_rs_c2");
    idle(DEF, LU, "lu_rs_c3");
    idle(DEF, DEF, "lu_rs_done");

    // load-use on rt
    step(1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU, "lu_rt");
    idle(DEF, LU, "lu_rt_c2");
    idle(DEF, LU, "lu_rt_c3");
    idle(DEF, DEF, "lu_rt_done");

    // r0 and non-load never stall
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, DEF, DEF, "r0_no_stall");
    step(1'b1, 5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, DEF, DEF, "no_memread");

    // branch wins over load-use and mc_start
    step(1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, BR, BR, "br_over_lu");
    idle(DEF, DEF, "after_br_lu");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, BR, BR, "br_over_mc");
    idle(DEF, DEF, "after_br_mc");

    // mc_done after 5 wait cycles
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, DEF, DEF, "mc_start");
    for (int i = 0; i < 5; i++) idle(MCW, MCW, "mc_wait");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF, DEF, "mc_done");
    idle(DEF, DEF, "mc_after");

    // timeout on the 8th wait cycle
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, DEF, DEF, "to_start");
    for (int i = 0; i < 7; i++) idle(MCW, MCW, "to_wait");
    idle(TO, TO, "mc_timeout");
    idle(DEF, DEF, "to_after");

    // mc_done on the timeout cycle suppresses the pulse
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, DEF, DEF, "dto_start");
    for (int i = 0; i < 7; i++) idle(MCW, MCW, "dto_wait");
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, DEF, DEF, "done_at_to");
    idle(DEF, DEF, "dto_after");

    // load-use deferred while in MC_WAIT
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, DEF, DEF, "def_start");
    step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, MCW, MCW, "def_lu_wait");
    step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, DEF, DEF, "def_lu_done");
    step(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU, "def_lu_run");
    idle(DEF, LU, "def_c2");
    idle(DEF, LU, "def_c3");
    idle(DEF, DEF, "def_done");

    // async reset while lsc3 is in LU_STALL
    step(1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU, "pre_async");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RST, RST, "async_rst");
    idle(DEF, DEF, "post_async");
    drain();

`ifdef HAZARD_STALL_STATS_EN
    check_stats(8'd0, 8'd0, "stats_after_rst");
    step(1'b1, 5'd1, 5'd2, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU, "st_lu");
    idle(DEF, LU, "st_c2");
    idle(DEF, LU, "st_c3");
    idle(DEF, DEF, "st_done");
    drain();
    check_stats(8'd1, 8'd3, "stats_count");
    @(posedge clk);
    #1 stats_clr = 1'b1;
    @(posedge clk);
    #1 stats_clr = 1'b0;
    check_stats(8'd0, 8'd0, "stats_clr");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
